// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Four-master round-robin arbiter for the shared address/control/write-data
// path. Ownership is registered and always one-hot; the bus parks on the last
// owner. A hold limit (MAX_HOLD) preempts an owner that keeps requesting while
// another master waits; MAX_HOLD = 0 disables preemption.
//
// Ports:
//   clk              single clock, rising-edge state updates
//   reset            asynchronous active-high reset (owner -> master 0)
//   m0_req..m3_req   level-sensitive bus requests
//   m0_grnt..m3_grnt registered one-hot grants
//   m_sel            registered index of the current owner
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m3_req,
    output logic       m0_grnt,
    output logic       m1_grnt,
    output logic       m2_grnt,
    output logic       m3_grnt,
    output logic [1:0] m_sel
);

    localparam int HW          = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
    localparam int ONE_I       = 1;
    localparam logic [HW-1:0] HOLD_LAST = HOLD_LAST_I[HW-1:0];
    localparam logic [HW-1:0] HOLD_ONE  = ONE_I[HW-1:0];

    logic [3:0]    req_s;
    logic [1:0]    owner_q;
    logic [1:0]    owner_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [3:0]    grnt_q;
    logic [3:0]    grnt_d;
    logic [1:0]    winner_s;
    logic [1:0]    cand_s;
    logic          others_s;

    assign req_s = {m3_req, m2_req, m1_req, m0_req};

    // Round-robin search: scan owner+3 down to owner+1 so the nearest
    // requester in rotation order is the last one written and wins.
    always_comb begin
        winner_s = owner_q;
        others_s = 1'b0;
        cand_s   = owner_q;
        for (int i = 3; i >= 1; i--) begin
            cand_s = owner_q + i[1:0];
            if (req_s[cand_s]) begin
                winner_s = cand_s;
                others_s = 1'b1;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Per-edge decision: release, park, preempt, hold (in that priority).
    always_comb begin
        owner_d = owner_q;
        hold_d  = hold_q;
        if (!req_s[owner_q]) begin
            // Release when someone else waits, otherwise park on the owner.
            hold_d = '0;
            if (others_s) begin
                owner_d = winner_s;
            end else begin
                owner_d = owner_q;
            end
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_s) begin
            owner_d = winner_s;
            hold_d  = '0;
        end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LAST)) begin
            hold_d = hold_q + HOLD_ONE;
        end else begin
            // Saturated, or preemption disabled (counter then stays at zero).
            hold_d = hold_q;
        end
        // Grants are decoded ahead of the register so the outputs are flops.
        grnt_d = 4'b0001 << owner_d;
    end

    // Ownership, hold counter and grant registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 2'd0;
            hold_q  <= '0;
            grnt_q  <= 4'b0001;
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grnt_q  <= grnt_d;
        end
    end

    assign m0_grnt = grnt_q[0];
    assign m1_grnt = grnt_q[1];
    assign m2_grnt = grnt_q[2];
    assign m3_grnt = grnt_q[3];
    assign m_sel   = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Two arbiters share clock, reset and requests: dut_a with MAX_HOLD = 4 and
// dut_b with MAX_HOLD = 0. Directed scenarios check fixed expectations; the
// random phase compares both against a rule-level reference model and checks
// one-hot grants, m_sel agreement and the bounded wait of dut_a.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    wire  [3:0] ga;
    wire  [3:0] gb;
    wire  [1:0] sela;
    wire  [1:0] selb;

    int checks = 0;
    int errors = 0;

    int mo [2];
    int mh [2];

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m1_req(req[1]), .m2_req(req[2]), .m3_req(req[3]),
        .m0_grnt(ga[0]), .m1_grnt(ga[1]), .m2_grnt(ga[2]), .m3_grnt(ga[3]),
        .m_sel(sela)
    );

    bus_arbiter #(.MAX_HOLD(0)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m1_req(req[1]), .m2_req(req[2]), .m3_req(req[3]),
        .m0_grnt(gb[0]), .m1_grnt(gb[1]), .m2_grnt(gb[2]), .m3_grnt(gb[3]),
        .m_sel(selb)
    );

    // Hold limit of model instance k.
    function automatic int lim_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    // First requester after owner o in rotation order, or -1.
    function automatic int search(input int o, input logic [3:0] r);
        for (int i = 1; i < 4; i++) begin
            if (r[(o + i) % 4]) return (o + i) % 4;
        end
        return -1;
    endfunction

    function automatic int next_owner(input int o, input int h, input int lim, input logic [3:0] r);
        int w;
        w = search(o, r);
        if (!r[o]) return (w >= 0) ? w : o;
        if (lim != 0 && h == lim - 1 && w >= 0) return w;
        return o;
    endfunction

    function automatic int next_hold(input int o, input int h, input int lim, input logic [3:0] r);
        int w;
        w = search(o, r);
        if (!r[o]) return 0;
        if (lim == 0) return 0;
        if (h == lim - 1) return (w >= 0) ? 0 : h;
        return h + 1;
    endfunction

    // Reference model: one owner/hold pair per configuration.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                mo[k] <= 0;
                mh[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mo[k] <= next_owner(mo[k], mh[k], lim_of(k), req);
                mh[k] <= next_hold(mo[k], mh[k], lim_of(k), req);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        checks++;
        if (ga !== 4'b0001 || sela !== 2'd0 || gb !== 4'b0001 || selb !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: ga=%b sela=%0d gb=%b selb=%0d, want 0001/0", ga, sela, gb, selb);
        end
        reset = 1'b0;
        req   = 4'b0100;
        @(negedge clk);
        checks++;
        if (ga !== 4'b0100 || sela !== 2'd2 || gb !== 4'b0100 || selb !== 2'd2) begin
            errors++;
            $display("FAIL m2_takes_bus: ga=%b sela=%0d gb=%b selb=%0d, want 0100/2", ga, sela, gb, selb);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ga !== 4'b0001 || sela !== 2'd0 || gb !== 4'b0001 || selb !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: ga=%b sela=%0d gb=%b selb=%0d, want 0001/0", ga, sela, gb, selb);
        end
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (ga !== 4'b0001 || sela !== 2'd0 || gb !== 4'b0001 || selb !== 2'd0) begin
                errors++;
                $display("FAIL park_m0 cyc %0d: ga=%b sela=%0d gb=%b selb=%0d, want 0001/0", c, ga, sela, gb, selb);
            end
        end
    endtask

    task automatic test_handoff();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (ga !== 4'b0100 || sela !== 2'd2 || gb !== 4'b0100 || selb !== 2'd2) begin
            errors++;
            $display("FAIL handoff_m2: ga=%b sela=%0d gb=%b selb=%0d, want 0100/2", ga, sela, gb, selb);
        end
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ga !== 4'b0100 || sela !== 2'd2 || gb !== 4'b0100 || selb !== 2'd2) begin
                errors++;
                $display("FAIL park_m2 cyc %0d: ga=%b sela=%0d gb=%b selb=%0d, want 0100/2", c, ga, sela, gb, selb);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] reqs [4];
        int         owners [4];
        reqs[0] = 4'b0010; owners[0] = 1;
        reqs[1] = 4'b1101; owners[1] = 2;
        reqs[2] = 4'b1001; owners[2] = 3;
        reqs[3] = 4'b0001; owners[3] = 0;
        for (int s = 0; s < 4; s++) begin
            req = reqs[s];
            @(negedge clk);
            checks++;
            if (ga !== (4'b0001 << owners[s]) || sela !== 2'(owners[s]) ||
                gb !== (4'b0001 << owners[s]) || selb !== 2'(owners[s])) begin
                errors++;
                $display("FAIL round_robin step %0d: ga=%b sela=%0d gb=%b selb=%0d, want owner %0d",
                         s, ga, sela, gb, selb, owners[s]);
            end
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_preempt();
        int want;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b0011;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            want = (e >= 4 && e <= 7) ? 1 : 0;
            checks++;
            if (ga !== (4'b0001 << want) || sela !== 2'(want)) begin
                errors++;
                $display("FAIL preempt edge %0d: ga=%b sela=%0d, want owner %0d", e, ga, sela, want);
            end
            checks++;
            if (gb !== 4'b0001 || selb !== 2'd0) begin
                errors++;
                $display("FAIL nopreempt_hold0 edge %0d: gb=%b selb=%0d, want 0001/0", e, gb, selb);
            end
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_no_preempt();
        req = 4'b1000;
        @(negedge clk);
        checks++;
        if (gb !== 4'b1000 || selb !== 2'd3) begin
            errors++;
            $display("FAIL m3_takes_bus: gb=%b selb=%0d, want 1000/3", gb, selb);
        end
        req = 4'b1001;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if (gb !== 4'b1000 || selb !== 2'd3) begin
                errors++;
                $display("FAIL m3_holds cyc %0d: gb=%b selb=%0d, want 1000/3", c, gb, selb);
            end
            checks++;
            if (ga !== (4'b0001 << mo[0]) || sela !== 2'(mo[0])) begin
                errors++;
                $display("FAIL hold4_model cyc %0d: ga=%b sela=%0d, want owner %0d", c, ga, sela, mo[0]);
            end
        end
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (gb !== 4'b0001 || selb !== 2'd0) begin
            errors++;
            $display("FAIL m0_after_release: gb=%b selb=%0d, want 0001/0", gb, selb);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_random();
        int use_left [4];
        int waited   [4];
        for (int i = 0; i < 4; i++) begin
            use_left[i] = 0;
            waited[i]   = 0;
        end
        req = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (ga !== (4'b0001 << mo[0]) || sela !== 2'(mo[0])) begin
                errors++;
                $display("FAIL rand_hold4 cyc %0d: ga=%b sela=%0d, want owner %0d", c, ga, sela, mo[0]);
            end
            checks++;
            if (gb !== (4'b0001 << mo[1]) || selb !== 2'(mo[1])) begin
                errors++;
                $display("FAIL rand_hold0 cyc %0d: gb=%b selb=%0d, want owner %0d", c, gb, selb, mo[1]);
            end
            checks++;
            if ($countones(ga) != 1 || ga[sela] !== 1'b1 || $countones(gb) != 1 || gb[selb] !== 1'b1) begin
                errors++;
                $display("FAIL onehot cyc %0d: ga=%b sela=%0d gb=%b selb=%0d", c, ga, sela, gb, selb);
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !ga[i]) waited[i]++;
                else waited[i] = 0;
                checks++;
                if (waited[i] > 3 * 4 + 1) begin
                    errors++;
                    $display("FAIL wait_bound m%0d cyc %0d: waited %0d, limit 13", i, c, waited[i]);
                end
            end
            // Masters keep requesting until they have had the bus for their burst.
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (ga[i]) begin
                        use_left[i]--;
                        if (use_left[i] <= 0) req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i]      = 1'b1;
                    use_left[i] = int'($urandom_range(1, 8));
                end
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        test_reset();
        test_handoff();
        test_round_robin();
        test_preempt();
        test_no_preempt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Four-master round-robin bus arbiter that sits in front of `bus_addr_dec` and the shared bus multiplexers. It decides which master drives the shared address, control and write-data path in each cycle. The address decoder then selects the target slave from that master's address. Ownership is registered and always one-hot; the bus parks on the last owner. An optional hold limit prevents one master from starving the others.

## Interface
Parameters:
- `MAX_HOLD`, 16: maximum consecutive requesting cycles an owner keeps the bus while another master waits. 0 disables preemption. Legal range 0..256.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m0_req` .. `m3_req` in 1 each: bus request from master n, level-sensitive. Master n holds it high for as long as it needs the bus.
- `m0_grnt` .. `m3_grnt` out 1 each: registered grant to master n. Exactly one is high at all times.
- `m_sel` out 2: registered index of the current owner. Drives the master-side bus muxes and equals the index of the high `mN_grnt`.

## Operation
- State:
  - `owner`: 2-bit current owner.
  - `hold_cnt`: `$clog2(MAX_HOLD)` bits, minimum 1.
  - Grant outputs are decoded from `owner` inside the registered stage. `m_sel == owner`.
- Reset, asserted asynchronously and independent of `clk`:
  - `owner` = 0, `m0_grnt` = 1, `m1..m3_grnt` = 0, `m_sel` = 0, `hold_cnt` = 0.
  - A reset in the middle of a transfer drops the current grant immediately.
- Next-owner search order is `owner+1`, `owner+2`, `owner+3`, modulo 4. The first master with its request high wins.
- Per-edge decision, evaluated in priority order:
  1. **Release:** the owner's request is low and at least one other request is high. `owner` becomes the search winner and `hold_cnt` becomes 0.
  2. **Park:** the owner's request is low and no request is high. `owner` is unchanged and `hold_cnt` becomes 0.
  3. **Preempt:** `MAX_HOLD` ≠ 0, the owner's request is high, `hold_cnt == MAX_HOLD-1`, and some other request is high. `owner` becomes the search winner and `hold_cnt` becomes 0.
  4. **Hold:** the owner's request is high and no preemption applies. `owner` is unchanged. `hold_cnt` increments and saturates at `MAX_HOLD-1`. When `MAX_HOLD` = 0, `hold_cnt` stays at 0.
- Special cases:
  - `MAX_HOLD` = 1: an owner whose request is high is preempted on every edge at which another master is requesting.
  - A parked owner that raises its request is already granted. It transfers starting that same cycle, with no arbitration latency.
  - If all four requests are high continuously, ownership rotates 0→1→2→3→0. Each master holds the bus for `MAX_HOLD` cycles.

## Timing
- Latency from request to grant:
  - The grant changes on the first rising edge at which the decision rules select the requester.
  - When the bus is free, a request seen at edge k produces a grant visible after edge k, i.e. 1 cycle.
  - The worst case for a waiting master is 3×`MAX_HOLD` + 1 cycles while all other masters hold.
- Release: the owner lowers its request in cycle c. The new owner's grant is high from cycle c+1. There is no dead cycle, and the old grant drops in the same cycle the new one rises.
- Simultaneous events:
  - Owner release together with new requests: the search picks the first requester in rotation order.
  - Preemption and release in the same cycle cannot both apply; release takes precedence.
- Outputs are registered and glitch-free. There are no combinational paths from requests to grants.
- Masters must sample their own grant and must not drive the bus before it is high. A master preempted mid-burst loses the bus after the edge and re-requests by keeping its request high.

## Test plan
- **Reset and park:** assert `reset` mid-cycle with `m2` owning → `m0_grnt`=1 and `m_sel`=0 immediately, without waiting for a clock edge. With all requests low for 10 cycles → grant stays on `m0`.
- **Simple handoff:** `m0_req` low, `m2_req` rises before edge k → `m2_grnt`=1 and `m_sel`=2 after edge k. Drop `m2_req` with no other requests → grant remains on `m2` (parked).
- **Round-robin order:** owner=1, then `m1` releases while `m0`, `m2` and `m3` are all requesting → grant goes to 2. After `m2` releases → grant goes to 3. After `m3` releases → grant goes to 0.
- **Hold-limit preemption** (`MAX_HOLD`=4): after reset `m0_req`=1 continuously, and `m1_req`=1 from cycle 1 → `m0` is granted for 4 cycles with its request high. `m1_grnt` rises after edge 4. `m0` regains the bus 4 cycles later if `m1` keeps requesting.
- **No preemption** (`MAX_HOLD`=0): `m3` holds its request for 100 cycles while `m0` requests → `m3_grnt` stays high throughout. `m0` is granted one edge after `m3_req` falls.
- **Invariant check (all runs):** every cycle, exactly one `mN_grnt` is high, its index equals `m_sel`, and no master waits longer than 3×`MAX_HOLD` + 1 cycles under random request traffic.
